spi_master_param: RTL and testbench
===================================

# spi_master_param

Parametrised full-duplex SPI master for the SPI link, the next generation after the fixed 12-bit transmit-only master. It adds the following:
- configurable word width and SCLK divider;
- all four CPOL/CPHA modes;
- MSB- or LSB-first ordering;
- MISO capture;
- multiple chip selects.

It sits between a local controller (start/done handshake) and external SPI slaves. Everything runs on one system clock; SCLK is a registered output, not a clock domain.

## Interface
- DATA_W, 12, bits per transfer (≥2)
- DIV, 10, system clocks per SCLK half-period (≥1)
- CSEL_W, 2, chip-select index width; NUM_CS = 2**CSEL_W
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  request transfer; sampled only in IDLE
- din  in  DATA_W  transmit word, latched on accepted start
- csel  in  CSEL_W  target slave, latched on accepted start
- cpol  in  1  idle SCLK level, latched on accepted start
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched on accepted start
- lsb_first  in  1  bit order for MOSI and MISO, latched on accepted start
- miso  in  1  serial data from slave
- sclk  out  1  SPI clock, registered
- mosi  out  1  serial data to slave, registered
- cs_n  out  NUM_CS  active-low selects; at most one low at any time
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of transfer
- dout  out  DATA_W  received word; valid from done until next done

## Operation
- States:
  - IDLE: sclk follows cpol each cycle; cs_n all 1. start=1 latches din/csel/cpol/cpha/lsb_first and moves to SETUP.
  - SETUP: cs_n[csel]=0. Lasts DIV cycles, then XFER.
  - XFER: 2*DATA_W SCLK edges, DIV cycles apart. Leading edges are odd-numbered, trailing edges even-numbered.
  - HOLD: DIV cycles after the last edge, SCLK at the latched cpol level. Then IDLE with done=1, busy=0, cs_n all 1.
- Bit order: the first bit is din[DATA_W-1] when lsb_first=0 and din[0] when lsb_first=1. MISO bits are placed in the same order.
- CPHA=0:
  - First bit is on mosi from SETUP entry.
  - miso is sampled at each leading edge.
  - mosi advances at each trailing edge except the last.
- CPHA=1:
  - mosi is 0 during SETUP.
  - mosi advances at each leading edge, starting with the first bit.
  - miso is sampled at each trailing edge.
- MISO sampling: miso is sampled on the same clk edge that registers the SCLK transition.
- Completion: mosi returns to 0 on entry to HOLD. dout updates only on entry to IDLE with the full word.
- start is ignored while busy=1. Config inputs may change freely except at the accepting edge.
- Counters:
  - Divider counter runs 0..DIV-1.
  - Edge counter needs a width of at least clog2(2*DATA_W+1) bits.
  - Neither counter wraps mid-state. Both clear on every state entry.

## Timing
- Reset (rst_n=0 at a rising edge) sets:
  - sclk=0, mosi=0, cs_n all 1, busy=0, done=0, dout=0, state IDLE.
- Reset mid-transfer aborts at the next edge with the same values. No done pulse is produced.
- Take T0 as the edge that accepts start:
  - At T0: busy=1, cs_n[csel]=0.
  - SCLK edge k (1..2*DATA_W) occurs at T0+k*DIV.
  - At T0+(2*DATA_W+1)*DIV: cs_n all 1, busy=0, done=1.
  - Next edge: done=0.
- With the defaults (DATA_W=12, DIV=10), start-to-done is 250 cycles.
- Back-to-back: start held high during the done cycle is accepted on that cycle's edge. cs_n is then high for exactly 1 cycle before falling again.
- DIV=1: SCLK toggles every clk cycle, giving clk/2. All rules above still hold.
- busy is a pure function of state (not IDLE). done never coincides with busy=1.

## Test plan
- Mode 0, MSB first:
  - Stimulus: DIV=10, din=12'hA5C, csel=2, miso looped to mosi.
  - Required: cs_n=4'b1011 during T0..T0+249; sclk idle 0, 24 edges; mosi serial 1010_0101_1100; done at T0+250; dout=12'hA5C.
- Mode 3, LSB first:
  - Stimulus: cpol=1, cpha=1, lsb_first=1, din=12'h001, miso tied 1.
  - Required: sclk idle 1; mosi=1 only during the first bit window; dout=12'hFFF.
- Start while busy: pulse start at T0+50 with din=12'hFFF → ignored; first transfer's dout and timing unchanged.
- Back-to-back: start held high continuously → cs_n high for exactly 1 cycle between transfers; done pulses 251 cycles apart.
- Reset mid-transfer: rst_n=0 at T0+100 for 1 cycle → next edge cs_n all 1, sclk=0, busy=0, no done; new start then completes normally.
- DIV=1 with DATA_W=8: sclk=clk/2; done at T0+17; dout matches the miso pattern 8'h3C.

Source files
------------

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: all four CPOL/CPHA modes, MSB/LSB-first,
// configurable word width and SCLK divider, one-hot active-low chip selects.
module spi_master_param #(
  parameter int DATA_W = 12,
  parameter int DIV    = 10,
  parameter int CSEL_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_W-1:0]      din_i,
  input  logic [CSEL_W-1:0]      csel_i,
  input  logic                   cpol_i,
  input  logic                   cpha_i,
  input  logic                   lsb_first_i,
  input  logic                   miso_i,
  output logic                   sclk_o,
  output logic                   mosi_o,
  output logic [2**CSEL_W-1:0]   cs_n_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_W-1:0]      dout_o
);

  localparam int NUM_CS = 2**CSEL_W;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int EDGE_W = $clog2(2*DATA_W+1);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(DIV-1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2*DATA_W-2);

  // IDLE: sclk tracks cpol, waits for start | SETUP: cs asserted, edge 1 on exit
  // XFER: edges 2..2*DATA_W                 | HOLD: cs held DIV cycles after last edge
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              tick;
  logic              edge_ev, lead_ev, last_ev;

  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] capture(input logic [DATA_W-1:0] w, input logic lsb,
                                               input logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    edge_ev = 1'b0;
    lead_ev = 1'b0;
    last_ev = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = cpol_i;
        cs_n_d = '1;
        div_d  = '0;
        edge_d = '0;
        if (start_i) begin
          state_d = SETUP;
          cpol_d  = cpol_i;
          cpha_d  = cpha_i;
          lsb_d   = lsb_first_i;
          cs_n_d  = ~(NUM_CS'(1) << csel_i);
          rx_d    = '0;
          // CPHA=0 presents the first bit before any edge; CPHA=1 waits for edge 1
          if (cpha_i) begin
            mosi_d = 1'b0;
            tx_d   = din_i;
          end else begin
            mosi_d = head_bit(din_i, lsb_first_i);
            tx_d   = advance(din_i, lsb_first_i);
          end
        end
      end
      SETUP: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          state_d = XFER;
          div_d   = '0;
          edge_d  = '0;
          edge_ev = 1'b1;
          lead_ev = 1'b1;
        end
      end
      XFER: begin
        div_d = div_q + 1'b1;
        if (tick) begin
          div_d   = '0;
          edge_ev = 1'b1;
          lead_ev = edge_q[0];
          edge_d  = edge_q + 1'b1;
          if (edge_q == EDGE_LAST) begin
            last_ev = 1'b1;
            state_d = HOLD;
            edge_d  = '0;
          end
        end
      end
      HOLD: begin
        sclk_d = cpol_q;
        div_d  = div_q + 1'b1;
        if (tick) begin
          state_d = IDLE;
          div_d   = '0;
          cs_n_d  = '1;
          done_d  = 1'b1;
          dout_d  = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sample when leading/cpha disagree, otherwise shift the next MOSI bit out
    if (edge_ev) begin
      sclk_d = ~sclk_q;
      if (lead_ev != cpha_q) begin
        rx_d = capture(rx_q, lsb_q, miso_i);
      end else if (!last_ev) begin
        mosi_d = head_bit(tx_q, lsb_q);
        tx_d   = advance(tx_q, lsb_q);
      end
      if (last_ev) mosi_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      div_q   <= '0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      cs_n_q  <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
    end
  end

  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign cs_n_o = cs_n_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign dout_o = dout_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: default 12-bit/DIV=10 instance plus an
// 8-bit/DIV=1 instance, with hand-computed expectations.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cpol, cpha, lsb, miso_tie, loop12;
  logic [11:0] din;
  logic [1:0]  csel;
  logic        miso, sclk, mosi, busy, done;
  logic [3:0]  cs_n;
  logic [11:0] dout;

  logic        start8;
  logic [7:0]  din8;
  logic [1:0]  csel8;
  logic        cpol8, cpha8, lsb8;
  logic        sclk8, mosi8, busy8, done8;
  logic [3:0]  cs_n8;
  logic [7:0]  dout8;

  int tests = 0;
  int fails = 0;

  int          cs_bad, edges, done_c, done_n, ones, first_one;
  logic [11:0] seq;
  logic        sclk0, busy0, busy_at_done;
  logic [3:0]  cs_at_done;

  always #5 clk = ~clk;

  assign miso = loop12 ? mosi : miso_tie;

  spi_master_param #(.DATA_W(12), .DIV(10), .CSEL_W(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .din_i(din), .csel_i(csel),
    .cpol_i(cpol), .cpha_i(cpha), .lsb_first_i(lsb), .miso_i(miso),
    .sclk_o(sclk), .mosi_o(mosi), .cs_n_o(cs_n), .busy_o(busy), .done_o(done),
    .dout_o(dout)
  );

  spi_master_param #(.DATA_W(8), .DIV(1), .CSEL_W(2)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start8), .din_i(din8), .csel_i(csel8),
    .cpol_i(cpol8), .cpha_i(cpha8), .lsb_first_i(lsb8), .miso_i(mosi8),
    .sclk_o(sclk8), .mosi_o(mosi8), .cs_n_o(cs_n8), .busy_o(busy8), .done_o(done8),
    .dout_o(dout8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 12-bit transfer; c counts samples taken after edge T0+c.
  // The slave-side MOSI bit is the value held just before each sampling edge.
  task automatic run12(input logic [11:0] d, input logic [1:0] cs, input logic [3:0] cs_exp,
                       input logic cp, input logic ph, input logic lsbf, input bit poke);
    logic prev;
    int   k;
    @(negedge clk);
    din = d; csel = cs; cpol = cp; cpha = ph; lsb = lsbf; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cs_bad = 0; edges = 0; done_c = -1; done_n = 0; ones = 0; first_one = -1; seq = '0;
    busy_at_done = 1'bx; cs_at_done = 'x;
    sclk0 = sclk; busy0 = busy; prev = sclk;
    for (int c = 0; c <= 260; c++) begin
      if (c > 0) @(negedge clk);
      if (c > 0 && sclk !== prev) edges++;
      prev = sclk;
      if (c <= 249 && cs_n !== cs_exp) cs_bad++;
      if (mosi === 1'b1) begin
        ones++;
        if (first_one < 0) first_one = c;
      end
      k = (c + 1) / 10;
      if ((c + 1) % 10 == 0 && k >= 1 && k <= 24 && (k % 2) == (ph ? 0 : 1))
        seq = {seq[10:0], mosi};
      if (done === 1'b1) begin
        done_n++;
        if (done_c < 0) begin
          done_c = c; busy_at_done = busy; cs_at_done = cs_n;
        end
      end
      if (poke && c == 50) begin start = 1'b1; din = 12'hFFF; end
      if (poke && c == 51) start = 1'b0;
    end
  endtask

  initial begin
    int d1, d2, cs_high, tog_bad, edges8, done8_c, nodone;
    logic prev8;

    rst_n = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0;
    miso_tie = 1'b0; loop12 = 1'b1; din = '0; csel = '0;
    start8 = 1'b0; din8 = '0; csel8 = 2'd0; cpol8 = 1'b0; cpha8 = 1'b0; lsb8 = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, 12'h000);
    check("rst_dout8", dout8, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, MSB first, loopback; a start pulse mid-transfer must be ignored
    run12(12'hA5C, 2'd2, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b1);
    check("m0_busy_t0", busy0, 1'b1);
    check("m0_sclk_idle", sclk0, 1'b0);
    check("m0_cs_window", cs_bad, 0);
    check("m0_edges", edges, 24);
    check("m0_mosi_seq", seq, 12'hA5C);
    check("m0_done_time", done_c, 250);
    check("m0_done_count", done_n, 1);
    check("m0_busy_at_done", busy_at_done, 1'b0);
    check("m0_cs_at_done", cs_at_done, 4'hF);
    check("m0_dout", dout, 12'hA5C);

    // Mode 3, LSB first, miso tied high
    @(negedge clk);
    cpol = 1'b1; loop12 = 1'b0; miso_tie = 1'b1;
    repeat (2) @(negedge clk);
    check("m3_sclk_idle_pre", sclk, 1'b1);
    run12(12'h001, 2'd1, 4'b1101, 1'b1, 1'b1, 1'b1, 1'b0);
    check("m3_sclk_idle", sclk0, 1'b1);
    check("m3_cs_window", cs_bad, 0);
    check("m3_edges", edges, 24);
    check("m3_mosi_seq", seq, 12'h800);
    check("m3_mosi_first", first_one, 10);
    check("m3_mosi_ones", ones, 20);
    check("m3_done_time", done_c, 250);
    check("m3_dout", dout, 12'hFFF);

    // Back-to-back with start held high
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; loop12 = 1'b1; miso_tie = 1'b0;
    repeat (2) @(negedge clk);
    din = 12'h3C5; csel = 2'd0; start = 1'b1;
    d1 = -1; d2 = -1; cs_high = 0;
    for (int i = 0; i < 600 && d2 < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (d1 < 0) d1 = i;
        else begin d2 = i; start = 1'b0; end
      end
      if (d1 >= 0 && d2 < 0 && cs_n === 4'hF) cs_high++;
    end
    start = 1'b0;
    check("b2b_spacing", d2 - d1, 251);
    check("b2b_cs_high", cs_high, 1);
    check("b2b_dout", dout, 12'h3C5);
    @(negedge clk);
    check("b2b_idle_after", busy, 1'b0);

    // Reset mid-transfer at T0+100
    @(negedge clk);
    din = 12'h123; csel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_cs_n", cs_n, 4'hF);
    check("rst_mid_sclk", sclk, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    rst_n = 1'b1;
    nodone = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) nodone++;
    end
    check("rst_mid_no_done", nodone, 0);
    run12(12'h5A3, 2'd3, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_cs", cs_bad, 0);
    check("post_rst_done_time", done_c, 250);
    check("post_rst_mosi_seq", seq, 12'h5A3);
    check("post_rst_dout", dout, 12'h5A3);

    // DIV=1, DATA_W=8, loopback mode 0
    @(negedge clk);
    din8 = 8'h3C; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    prev8 = sclk8; tog_bad = 0; edges8 = 0; done8_c = -1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c <= 16 && sclk8 === prev8) tog_bad++;
      if (sclk8 !== prev8) edges8++;
      prev8 = sclk8;
      if (done8 === 1'b1 && done8_c < 0) done8_c = c;
    end
    check("div1_toggle", tog_bad, 0);
    check("div1_edges", edges8, 16);
    check("div1_done_time", done8_c, 17);
    check("div1_dout", dout8, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
